i2c_master_arbiter: RTL
=======================

Name: i2c_master_arbiter

Overview:
Round-robin scheduler that shares one I2C_MASTER between NREQ requesters. It latches a requester's transaction descriptor (slave address, direction, byte count) and drives the master's Start/SlaveAddress/RorW/NBytes/DataToSlave. It streams write bytes from, and read bytes to, the granted requester one byte at a time. It reports completion, address NACK and a bus-stall timeout per transaction.

Parameters:
ADDRESSLENGTH, 8, slave address width; matches I2C_MASTER.
NREQ, 2, number of requesters (2..8).
TIMEOUT, 4096, Clk cycles without master progress before abort.

Ports:
Clk  in  1  system clock, all logic on posedge
Rst  in  1  asynchronous, active-low reset
Req  in  NREQ  bit i: requester i wants a transaction; held until its Done pulse
ReqAddress  in  NREQ*ADDRESSLENGTH  slice i: target slave address
ReqRorW  in  NREQ  bit i: 1 = write to slave, 0 = read from slave
ReqNBytes  in  NREQ*4  slice i: byte count
ReqWrData  in  NREQ*8  slice i: next write byte of requester i
Grant  out  NREQ  one-hot owner of the master; 0 when idle
WrDataTake  out  NREQ  1-cycle pulse: current ReqWrData slice consumed; next byte valid by the following cycle
RdData  out  8  last byte read from slave
RdDataValid  out  NREQ  1-cycle pulse to owner when RdData updates
Done  out  NREQ  1-cycle completion pulse to owner
Error  out  2  valid with Done: 00 ok, 01 address NACK, 10 timeout, 11 NBytes==0
Start  out  1  to master Start
SlaveAddress  out  ADDRESSLENGTH  to master
RorW  out  1  to master
NBytes  out  4  to master
DataToSlave  out  8  to master
DataFromSlave  in  8  from master
ByteDone  in  1  master pulse: one data byte plus ack phase finished
AddrNack  in  1  master pulse: address phase received NACK
MasterIdle  in  1  high when master FSM is in its wait state (MasterState==0)

Behaviour:
- Reset (Rst low, asynchronous, also mid-transaction): every output 0, FSM to IDLE, byte counter and timer 0, RR pointer = NREQ-1 so requester 0 has first priority. Start drops immediately.
- States: IDLE, LAUNCH, XFER, WAITSTOP, FINISH.
- IDLE: Start=0, Grant=0. If any Req is high, select the first set bit searching from pointer+1 with wrap. Latch its address, RorW and NBytes into shadow registers, which drive SlaveAddress/RorW/NBytes. Set Grant one-hot. Next state LAUNCH. Req changes after latching are ignored.
- LAUNCH (1 cycle):
  - If latched NBytes==0: no bus activity; go to FINISH with Error=11.
  - If write: load DataToSlave from ReqWrData[owner] and pulse WrDataTake[owner].
  - Otherwise: set Start=1, load counter=NBytes, clear timer, go to XFER.
- XFER:
  - On ByteDone, counter decrements.
  - Write with counter>1 before decrement: load the next byte into DataToSlave and pulse WrDataTake in the same cycle.
  - Read: capture DataFromSlave into RdData and pulse RdDataValid[owner] in the same cycle.
  - When the counter reaches 0: Start=0, go to WAITSTOP with Error=00.
  - AddrNack: Start=0, Error=01, go to WAITSTOP.
  - Timer increments each cycle and clears on ByteDone/AddrNack. At TIMEOUT-1: Start=0, Error=10, go to WAITSTOP.
- Priority on the same cycle: AddrNack > ByteDone > timeout.
- WAITSTOP: wait for MasterIdle=1, then go to FINISH. If the timer (cleared on entry) expires first, go to FINISH with Error=10.
- FINISH (1 cycle):
  - Pulse Done[owner] with Error valid; clear Grant.
  - Set pointer=owner and go to IDLE.
  - At least one IDLE cycle separates consecutive grants.
- Error holds until the next FINISH. RdData holds until the next read capture.
- Requester dropping Req mid-transaction: the transaction still completes and Done still pulses.

Test Plan:
- Reset: hold Rst low with Req=2'b11 -> Grant=0, Start=0, Done=0. Release Rst -> Grant=2'b01 first.
- Write: requester 0, address 8'hAA, RorW=1, NBytes=2, bytes 8'hF0 then 8'hAA -> two WrDataTake pulses, then Done[0] with Error=00. Slave memory[15:0]=16'hAAF0.
- Read-back: requester 1, address 8'hAA, RorW=0, NBytes=2 -> RdDataValid[1] twice with RdData 8'hF0 then 8'hAA, then Done[1] with Error=00.
- NACK: address 8'hAB (absent) -> AddrNack, Start drops, Done with Error=01, no RdDataValid/WrDataTake pulses.
- Fairness: Req=2'b11 held continuously -> grants alternate 01,10,01,10. NBytes=0 request -> Done with Error=11 within 3 cycles, Start never asserted.
- Timeout: force ByteDone low with TIMEOUT=64 -> Start drops after 64 cycles in XFER, Done with Error=10. Rst pulse mid-XFER -> Start=0 asynchronously.

Source files
------------

// File: rtl/i2c_master_arbiter_if.sv
// Bus between the arbiter and the shared I2C_MASTER.
// The master modport is the arbiter's view; the slave modport is the I2C_MASTER's view.
interface i2c_master_arbiter_if #(
  parameter int ADDRESSLENGTH = 8
);
  logic                     Start;
  logic [ADDRESSLENGTH-1:0] SlaveAddress;
  logic                     RorW;
  logic [3:0]               NBytes;
  logic [7:0]               DataToSlave;
  logic [7:0]               DataFromSlave;
  logic                     ByteDone;
  logic                     AddrNack;
  logic                     MasterIdle;

  modport master (
    output Start, SlaveAddress, RorW, NBytes, DataToSlave,
    input  DataFromSlave, ByteDone, AddrNack, MasterIdle
  );

  modport slave (
    input  Start, SlaveAddress, RorW, NBytes, DataToSlave,
    output DataFromSlave, ByteDone, AddrNack, MasterIdle
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin scheduler that shares one I2C_MASTER between NREQ requesters,
// streaming bytes to/from the granted requester and reporting completion status.
module i2c_master_arbiter #(
  parameter int ADDRESSLENGTH = 8,
  parameter int NREQ          = 2,
  parameter int TIMEOUT       = 4096
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [NREQ-1:0]               Req,
  input  logic [NREQ*ADDRESSLENGTH-1:0] ReqAddress,
  input  logic [NREQ-1:0]               ReqRorW,
  input  logic [NREQ*4-1:0]             ReqNBytes,
  input  logic [NREQ*8-1:0]             ReqWrData,
  output logic [NREQ-1:0]               Grant,
  output logic [NREQ-1:0]               WrDataTake,
  output logic [7:0]                    RdData,
  output logic [NREQ-1:0]               RdDataValid,
  output logic [NREQ-1:0]               Done,
  output logic [1:0]                    Error,
  i2c_master_arbiter_if.master          bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW   = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, XFER, WAITSTOP, FINISH} stateT;

  stateT                    state, stateNext;
  logic [IDXW-1:0]          ptr, ptrNext;
  logic [IDXW-1:0]          owner, ownerNext;
  logic [ADDRESSLENGTH-1:0] shAddr, shAddrNext;
  logic                     shRorW, shRorWNext;
  logic [3:0]               shNBytes, shNBytesNext;
  logic [3:0]               counter, counterNext;
  logic [TW-1:0]            timer, timerNext;
  logic                     startReg, startNext;
  logic [7:0]               dataToSlave, dataToSlaveNext;
  logic [1:0]               errCode, errCodeNext;
  logic [NREQ-1:0]          grantNext, wrTakeNext, rdValidNext, doneNext;
  logic [7:0]               rdDataNext;
  logic [1:0]               errorNext;
  logic [NREQ-1:0]          effReq;
  logic [IDXW-1:0]          pick;
  logic [7:0]               ownerWrByte;
  logic                     timerExpired;

  function automatic logic [IDXW-1:0] rrPick(input logic [NREQ-1:0] r, input logic [IDXW-1:0] p);
    logic [IDXW-1:0] sel;
    logic            hit;
    int              idx;
    sel = p;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(p) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && r[idx]) begin
        hit = 1'b1;
        sel = IDXW'(idx);
      end
    end
    return sel;
  endfunction

  // A requester still sees its own Done this cycle and has not yet dropped Req,
  // so it is masked to avoid being re-granted for a transaction it already finished.
  assign effReq       = Req & ~Done;
  assign pick         = rrPick(effReq, ptr);
  assign ownerWrByte  = ReqWrData[int'(owner)*8 +: 8];
  assign timerExpired = (timer == TW'(TIMEOUT - 1));

  assign bus.Start        = startReg;
  assign bus.SlaveAddress = shAddr;
  assign bus.RorW         = shRorW;
  assign bus.NBytes       = shNBytes;
  assign bus.DataToSlave  = dataToSlave;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      ptr         <= IDXW'(NREQ - 1);
      owner       <= '0;
      shAddr      <= '0;
      shRorW      <= 1'b0;
      shNBytes    <= '0;
      counter     <= '0;
      timer       <= '0;
      startReg    <= 1'b0;
      dataToSlave <= '0;
      errCode     <= '0;
      Grant       <= '0;
      WrDataTake  <= '0;
      RdData      <= '0;
      RdDataValid <= '0;
      Done        <= '0;
      Error       <= '0;
    end else begin
      state       <= stateNext;
      ptr         <= ptrNext;
      owner       <= ownerNext;
      shAddr      <= shAddrNext;
      shRorW      <= shRorWNext;
      shNBytes    <= shNBytesNext;
      counter     <= counterNext;
      timer       <= timerNext;
      startReg    <= startNext;
      dataToSlave <= dataToSlaveNext;
      errCode     <= errCodeNext;
      Grant       <= grantNext;
      WrDataTake  <= wrTakeNext;
      RdData      <= rdDataNext;
      RdDataValid <= rdValidNext;
      Done        <= doneNext;
      Error       <= errorNext;
    end
  end

  always_comb begin
    stateNext       = state;
    ptrNext         = ptr;
    ownerNext       = owner;
    shAddrNext      = shAddr;
    shRorWNext      = shRorW;
    shNBytesNext    = shNBytes;
    counterNext     = counter;
    timerNext       = timer;
    startNext       = startReg;
    dataToSlaveNext = dataToSlave;
    errCodeNext     = errCode;
    grantNext       = Grant;
    wrTakeNext      = '0;
    rdDataNext      = RdData;
    rdValidNext     = '0;
    doneNext        = '0;
    errorNext       = Error;

    case (state)
      IDLE: begin
        startNext = 1'b0;
        grantNext = '0;
        if (|effReq) begin
          ownerNext    = pick;
          shAddrNext   = ReqAddress[int'(pick)*ADDRESSLENGTH +: ADDRESSLENGTH];
          shRorWNext   = ReqRorW[pick];
          shNBytesNext = ReqNBytes[int'(pick)*4 +: 4];
          grantNext    = NREQ'(1) << pick;
          stateNext    = LAUNCH;
        end
      end

      LAUNCH: begin
        if (shNBytes == 4'd0) begin
          errCodeNext = 2'b11;
          stateNext   = FINISH;
        end else begin
          if (shRorW) begin
            dataToSlaveNext = ownerWrByte;
            wrTakeNext      = Grant;
          end
          startNext   = 1'b1;
          counterNext = shNBytes;
          timerNext   = '0;
          stateNext   = XFER;
        end
      end

      // AddrNack wins over ByteDone, which wins over the stall timer.
      XFER: begin
        if (bus.AddrNack) begin
          startNext   = 1'b0;
          errCodeNext = 2'b01;
          timerNext   = '0;
          stateNext   = WAITSTOP;
        end else if (bus.ByteDone) begin
          timerNext   = '0;
          counterNext = counter - 4'd1;
          if (shRorW) begin
            if (counter > 4'd1) begin
              dataToSlaveNext = ownerWrByte;
              wrTakeNext      = Grant;
            end
          end else begin
            rdDataNext  = bus.DataFromSlave;
            rdValidNext = Grant;
          end
          if (counter <= 4'd1) begin
            startNext   = 1'b0;
            errCodeNext = 2'b00;
            stateNext   = WAITSTOP;
          end
        end else if (timerExpired) begin
          startNext   = 1'b0;
          errCodeNext = 2'b10;
          timerNext   = '0;
          stateNext   = WAITSTOP;
        end else begin
          timerNext = timer + TW'(1);
        end
      end

      WAITSTOP: begin
        if (bus.MasterIdle) begin
          stateNext = FINISH;
        end else if (timerExpired) begin
          errCodeNext = 2'b10;
          stateNext   = FINISH;
        end else begin
          timerNext = timer + TW'(1);
        end
      end

      FINISH: begin
        doneNext  = Grant;
        errorNext = errCode;
        grantNext = '0;
        ptrNext   = owner;
        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule
